// File: rtl/par_serializer.sv
// par_serializer: DATA_W-bit valid/ready words to a throttled serial stream.
// Define PAR_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module par_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pll_in,
  input  logic              pll_vld,
  output logic              pll_rdy,
  input  logic              srl_en,
  output logic              srl_out,
  output logic              srl_vld,
  output logic              srl_start,
  output logic              srl_last,
  output logic              srl_ongoing
);

`ifdef PAR_SERIALIZER_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] LAST_BC = CNT_W'(FRAME_W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] r_pr;
  logic              r_pv;
  logic              r_rdy;
  logic [CNT_W-1:0]  r_bc;

  logic              w_shift;
  logic              w_acc;
  logic              w_last;
  logic              w_free;
  logic              w_data_bit;
  logic              w_bit;
  logic              w_pv_nxt;
  logic [DATA_W-1:0] w_sr_nxt;

  assign w_shift    = (r_state == S_SHIFT);
  assign w_acc      = pll_vld && r_rdy;
  assign w_last     = w_shift && (r_bc == LAST_BC);
  assign w_free     = !w_shift || (w_last && srl_en);
  assign w_data_bit = LSB_FIRST ? r_sr[0] : r_sr[DATA_W-1];
  assign w_sr_nxt   = LSB_FIRST ? (r_sr >> 1) : (r_sr << 1);

`ifdef PAR_SERIALIZER_PARITY_EN
  logic r_par;
  logic r_ppar;
  logic w_is_par;

  assign w_is_par = (r_bc == CNT_W'(DATA_W));
  assign w_bit    = w_is_par ? r_par : w_data_bit;
`else
  assign w_bit    = w_data_bit;
`endif

  // Pending flag as it will be after this edge; pll_rdy tracks it so a
  // word landing in PR blocks the very next cycle.
  always_comb begin
    w_pv_nxt = r_pv;
    if (w_free) begin
      w_pv_nxt = r_pv && w_acc;
    end else if (w_acc) begin
      w_pv_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_pr    <= '0;
      r_pv    <= 1'b0;
      r_rdy   <= 1'b0;
      r_bc    <= '0;
`ifdef PAR_SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
      r_ppar  <= 1'b0;
`endif
    end else begin
      r_pv  <= w_pv_nxt;
      r_rdy <= !w_pv_nxt;
      if (w_free) begin
        if (r_pv) begin
          r_sr    <= r_pr;
          r_bc    <= '0;
          r_state <= S_SHIFT;
`ifdef PAR_SERIALIZER_PARITY_EN
          r_par   <= r_ppar;
`endif
          if (w_acc) begin
            r_pr   <= pll_in;
`ifdef PAR_SERIALIZER_PARITY_EN
            r_ppar <= ^pll_in;
`endif
          end
        end else if (w_acc) begin
          r_sr    <= pll_in;
          r_bc    <= '0;
          r_state <= S_SHIFT;
`ifdef PAR_SERIALIZER_PARITY_EN
          r_par   <= ^pll_in;
`endif
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        if (srl_en) begin
          r_sr <= w_sr_nxt;
          r_bc <= r_bc + CNT_W'(1);
        end
        if (w_acc) begin
          r_pr   <= pll_in;
`ifdef PAR_SERIALIZER_PARITY_EN
          r_ppar <= ^pll_in;
`endif
        end
      end
    end
  end

  assign pll_rdy     = r_rdy;
  assign srl_out     = w_shift && w_bit;
  assign srl_vld     = w_shift;
  assign srl_start   = w_shift && (r_bc == '0);
  assign srl_last    = w_last;
  assign srl_ongoing = w_shift || r_pv;

endmodule
